// File: rtl/vu_pkg.sv
// Shared types and constants for the stereo VU-meter scheduler.
package vu_pkg;

    localparam int VU_LEVEL_W  = 32;
    localparam int VU_SAMPLE_W = 16;
    localparam int VU_MAG_W    = VU_SAMPLE_W + 1;
    localparam int VU_NUM_LEDS = 6;

    // Default LED thresholds, strictly increasing.
    localparam logic [VU_LEVEL_W-1:0] VU_TH1_DEF = 32'd1000;
    localparam logic [VU_LEVEL_W-1:0] VU_TH2_DEF = 32'd3000;
    localparam logic [VU_LEVEL_W-1:0] VU_TH3_DEF = 32'd9000;
    localparam logic [VU_LEVEL_W-1:0] VU_TH4_DEF = 32'd20000;
    localparam logic [VU_LEVEL_W-1:0] VU_TH5_DEF = 32'd40000;
    localparam logic [VU_LEVEL_W-1:0] VU_TH6_DEF = 32'd80000;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        RIGHT = 2'd1,
        MAX   = 2'd2,
        ALT   = 2'd3
    } vu_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        UPD_L = 2'd1,
        UPD_R = 2'd2
    } vu_seq_state_e;

    // Latched stereo sample pair.
    typedef struct packed {
        logic signed [VU_SAMPLE_W-1:0] l;
        logic signed [VU_SAMPLE_W-1:0] r;
    } vu_pair_t;

    // Thermometer code: bit k is set when level exceeds threshold k.
    function automatic logic [VU_NUM_LEDS-1:0] vu_thermo(
        input logic [VU_LEVEL_W-1:0]                  level,
        input logic [VU_NUM_LEDS-1:0][VU_LEVEL_W-1:0] th
    );
        logic [VU_NUM_LEDS-1:0] t;
        for (int k = 0; k < VU_NUM_LEDS; k++) begin
            t[k] = (level > th[k]);
        end
        return t;
    endfunction

endpackage

// File: rtl/vu_level_update.sv
// Shared leaky-integrator step: |sample|, decay, add, saturate.
module vu_level_update
    import vu_pkg::*;
#(
    parameter int DECAY_SHIFT = 11,
    parameter int SCALE_SHIFT = 10
) (
    input  logic signed [VU_SAMPLE_W-1:0] sample_i,
    input  logic        [VU_LEVEL_W-1:0]  level_i,
    output logic        [VU_LEVEL_W-1:0]  level_o
);

    logic [VU_MAG_W-1:0]   ext;
    logic [VU_MAG_W-1:0]   mag;
    logic [VU_LEVEL_W:0]   sum;

    // 17-bit magnitude so -32768 maps to 32768; the decay term never exceeds
    // the level, so only the carry out of bit 31 needs saturating.
    always_comb begin
        ext     = {sample_i[VU_SAMPLE_W-1], sample_i};
        mag     = sample_i[VU_SAMPLE_W-1] ? (~ext + 1'b1) : ext;
        sum     = {1'b0, level_i}
                - {1'b0, (level_i >> DECAY_SHIFT)}
                + (VU_LEVEL_W+1)'(mag >> SCALE_SHIFT);
        level_o = sum[VU_LEVEL_W] ? '1 : sum[VU_LEVEL_W-1:0];
    end

endmodule

// File: rtl/vu_stereo_sched.sv
// Stereo VU scheduler: one shared integrator unit time-multiplexed over
// left/right, plus LED refresh divider and channel display selection.
module vu_stereo_sched
    import vu_pkg::*;
#(
    parameter int                    DECAY_SHIFT = 11,
    parameter int                    SCALE_SHIFT = 10,
    parameter logic [VU_LEVEL_W-1:0] TH1         = VU_TH1_DEF,
    parameter logic [VU_LEVEL_W-1:0] TH2         = VU_TH2_DEF,
    parameter logic [VU_LEVEL_W-1:0] TH3         = VU_TH3_DEF,
    parameter logic [VU_LEVEL_W-1:0] TH4         = VU_TH4_DEF,
    parameter logic [VU_LEVEL_W-1:0] TH5         = VU_TH5_DEF,
    parameter logic [VU_LEVEL_W-1:0] TH6         = VU_TH6_DEF,
    parameter int                    LED_DIV     = 540000,
    parameter int                    ALT_TICKS   = 50
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          sample_stb_i,
    input  logic signed [VU_SAMPLE_W-1:0] left_sample_i,
    input  logic signed [VU_SAMPLE_W-1:0] right_sample_i,
    input  logic        [1:0]             mode_i,
    output logic        [VU_NUM_LEDS-1:0] leds_o,
    output logic                          chan_o,
    output logic        [VU_LEVEL_W-1:0]  level_l_o,
    output logic        [VU_LEVEL_W-1:0]  level_r_o,
    output logic                          busy_o,
    output logic                          overrun_o
);

    localparam int DIV_W = (LED_DIV > 1) ? $clog2(LED_DIV) : 1;
    localparam int ALT_W = (ALT_TICKS > 1) ? $clog2(ALT_TICKS) : 1;
    localparam logic [VU_NUM_LEDS-1:0][VU_LEVEL_W-1:0] TH_ARR =
        {TH6, TH5, TH4, TH3, TH2, TH1};

    vu_seq_state_e           state_q;
    vu_pair_t                hold_q;
    logic [VU_LEVEL_W-1:0]   level_l_q, level_r_q;
    logic                    busy_q, overrun_q;

    logic [DIV_W-1:0]        div_q;
    logic                    tick_q;
    logic [ALT_W-1:0]        alt_cnt_q;
    logic                    alt_q;
    logic [VU_NUM_LEDS-1:0]  leds_q;
    logic                    chan_q;

    logic signed [VU_SAMPLE_W-1:0] upd_sample_d;
    logic [VU_LEVEL_W-1:0]         upd_level_d;
    logic [VU_LEVEL_W-1:0]         upd_new_d;
    logic                          sel_chan_d;
    logic [VU_LEVEL_W-1:0]         sel_level_d;

    // Operand mux for the shared update unit: right operands only in UPD_R.
    always_comb begin
        upd_sample_d = hold_q.l;
        upd_level_d  = level_l_q;
        if (state_q == UPD_R) begin
            upd_sample_d = hold_q.r;
            upd_level_d  = level_r_q;
        end
    end

    vu_level_update #(
        .DECAY_SHIFT (DECAY_SHIFT),
        .SCALE_SHIFT (SCALE_SHIFT)
    ) u_upd (
        .sample_i (upd_sample_d),
        .level_i  (upd_level_d),
        .level_o  (upd_new_d)
    );

    // Sequencer: latch pair, update left, update right; strobes while busy drop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            level_l_q <= '0;
            level_r_q <= '0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (sample_stb_i) begin
                        hold_q.l <= left_sample_i;
                        hold_q.r <= right_sample_i;
                        state_q  <= UPD_L;
                        busy_q   <= 1'b1;
                    end
                end
                UPD_L: begin
                    level_l_q <= upd_new_d;
                    overrun_q <= sample_stb_i;
                    state_q   <= UPD_R;
                end
                UPD_R: begin
                    level_r_q <= upd_new_d;
                    overrun_q <= sample_stb_i;
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Channel choice for the display, from pre-write level registers.
    always_comb begin
        sel_chan_d = 1'b0;
        case (vu_mode_e'(mode_i))
            LEFT:    sel_chan_d = 1'b0;
            RIGHT:   sel_chan_d = 1'b1;
            MAX:     sel_chan_d = (level_r_q > level_l_q);
            ALT:     sel_chan_d = alt_q;
            default: sel_chan_d = 1'b0;
        endcase
        sel_level_d = sel_chan_d ? level_r_q : level_l_q;
    end

    // LED refresh divider and tick strobe.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DIV_W'(LED_DIV - 1));
            div_q  <= (div_q == DIV_W'(LED_DIV - 1)) ? '0 : div_q + 1'b1;
        end
    end

    // Alternate-mode channel swap and display register, both stepped on tick.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            alt_cnt_q <= '0;
            alt_q     <= 1'b0;
            leds_q    <= '0;
            chan_q    <= 1'b0;
        end else if (tick_q) begin
            if (alt_cnt_q == ALT_W'(ALT_TICKS - 1)) begin
                alt_cnt_q <= '0;
                alt_q     <= ~alt_q;
            end else begin
                alt_cnt_q <= alt_cnt_q + 1'b1;
            end
            leds_q <= vu_thermo(sel_level_d, TH_ARR);
            chan_q <= sel_chan_d;
        end
    end

    assign leds_o    = leds_q;
    assign chan_o    = chan_q;
    assign level_l_o = level_l_q;
    assign level_r_o = level_r_q;
    assign busy_o    = busy_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_vu_stereo_sched.sv
// Bench for vu_stereo_sched: cycle-level reference model plus directed vectors.
module tb_vu_stereo_sched;

    localparam int LED_DIV   = 8;
    localparam int ALT_TICKS = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               stb = 1'b0;
    logic signed [15:0] lsmp = '0;
    logic signed [15:0] rsmp = '0;
    logic [1:0]         mode = 2'd0;
    logic [5:0]         leds;
    logic               chan;
    logic [31:0]        lvl_l, lvl_r;
    logic               busy, ovr;

    vu_stereo_sched #(
        .DECAY_SHIFT (11),
        .SCALE_SHIFT (10),
        .LED_DIV     (LED_DIV),
        .ALT_TICKS   (ALT_TICKS)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .sample_stb_i   (stb),
        .left_sample_i  (lsmp),
        .right_sample_i (rsmp),
        .mode_i         (mode),
        .leds_o         (leds),
        .chan_o         (chan),
        .level_l_o      (lvl_l),
        .level_r_o      (lvl_r),
        .busy_o         (busy),
        .overrun_o      (ovr)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    longint th[6] = '{1000, 3000, 9000, 20000, 40000, 80000};

    longint m_l, m_r;          // integrator levels
    int     m_hl, m_hr;        // latched samples
    int     m_left;            // update cycles still owed (0 = idle)
    bit     m_ovr;
    int     m_edges;           // clock edges since reset
    int     m_ticks;           // ticks seen since reset
    logic [5:0] m_leds;
    bit     m_chan;

    function automatic longint upd(input longint lv, input int s);
        longint mag, nv;
        mag = (s < 0) ? -s : s;
        nv  = lv - (lv >> 11) + (mag >> 10);
        if (nv > 64'hFFFF_FFFF) nv = 64'hFFFF_FFFF;
        return nv;
    endfunction

    function automatic logic [5:0] thermo(input longint lv);
        logic [5:0] t;
        for (int k = 0; k < 6; k++) t[k] = (lv > th[k]);
        return t;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_l = 0; m_r = 0; m_hl = 0; m_hr = 0; m_left = 0; m_ovr = 0;
            m_edges = 0; m_ticks = 0; m_leds = '0; m_chan = 0;
        end else begin
            // A refresh tick is live in every cycle following a multiple of LED_DIV edges.
            if (m_edges > 0 && (m_edges % LED_DIV) == 0) begin
                bit c;
                case (mode)
                    2'd0: c = 0;
                    2'd1: c = 1;
                    2'd2: c = (m_r > m_l);
                    default: c = ((m_ticks / ALT_TICKS) % 2) == 1;
                endcase
                m_chan = c;
                m_leds = thermo(c ? m_r : m_l);
                m_ticks++;
            end
            m_ovr = (m_left != 0) && stb;
            if (m_left == 2) begin
                m_l = upd(m_l, m_hl); m_left = 1;
            end else if (m_left == 1) begin
                m_r = upd(m_r, m_hr); m_left = 0;
            end else if (stb) begin
                m_hl = lsmp; m_hr = rsmp; m_left = 2;
            end
            m_edges++;
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_leds",    32'(leds),  32'(m_leds));
            chk("m_chan",    32'(chan),  32'(m_chan));
            chk("m_level_l", lvl_l,      m_l[31:0]);
            chk("m_level_r", lvl_r,      m_r[31:0]);
            chk("m_busy",    32'(busy),  32'(m_left != 0));
            chk("m_overrun", 32'(ovr),   32'(m_ovr));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1; stb = 1'b0;
        cyc(n);
        rst = 1'b0;
    endtask

    initial begin
        int  iter;
        int  changes;
        bit  prev;
        @(posedge clk);
        chk_en = 1;

        // Reset: two cycles, then idle with no strobes.
        @(negedge clk);
        do_reset(2);
        chk("rst_leds", 32'(leds), 32'd0);
        chk("rst_chan", 32'(chan), 32'd0);
        chk("rst_lvl_l", lvl_l, 32'd0);
        chk("rst_lvl_r", lvl_r, 32'd0);
        cyc(3);
        chk("rst_busy_idle", 32'(busy), 32'd0);
        chk("rst_ovr", 32'(ovr), 32'd0);

        // Single update: -1024 -> 1, 2048 -> 2.
        lsmp = -16'sd1024; rsmp = 16'sd2048; stb = 1'b1;
        cyc(1); stb = 1'b0;                         // t+1
        chk("single_busy_t1", 32'(busy), 32'd1);
        chk("single_lvl_l_t1", lvl_l, 32'd0);
        cyc(1);                                     // t+2
        chk("single_busy_t2", 32'(busy), 32'd1);
        chk("single_lvl_l_t2", lvl_l, 32'd1);
        chk("single_lvl_r_t2", lvl_r, 32'd0);
        cyc(1);                                     // t+3
        chk("single_busy_t3", 32'(busy), 32'd0);
        chk("single_lvl_r_t3", lvl_r, 32'd2);
        cyc(2);

        // Overrun: strobes at t and t+1, then t+3.
        do_reset(1);
        lsmp = -16'sd1024; rsmp = 16'sd2048; stb = 1'b1;
        cyc(1);                                     // t+1, still strobing
        chk("ovr_t1", 32'(ovr), 32'd0);
        cyc(1); stb = 1'b0;                         // t+2
        chk("ovr_pulse_t2", 32'(ovr), 32'd1);
        cyc(1);                                     // t+3
        chk("ovr_clear_t3", 32'(ovr), 32'd0);
        chk("ovr_lvl_r_once", lvl_r, 32'd2);
        chk("ovr_lvl_l_once", lvl_l, 32'd1);
        stb = 1'b1;
        cyc(1); stb = 1'b0;                         // t+4
        chk("ovr_accept_t3", 32'(busy), 32'd1);
        cyc(2);
        chk("ovr_second_lvl_r", lvl_r, 32'd4);
        cyc(2);

        // Max mode: ramp left with full-scale negative samples.
        do_reset(1);
        mode = 2'd2; lsmp = -16'sd32768; rsmp = 16'sd0;
        iter = 0;
        while (lvl_l <= 32'd40000 && iter < 4000) begin
            stb = 1'b1; cyc(1); stb = 1'b0; cyc(3);
            iter++;
        end
        if (iter >= 4000) begin
            n_cmp++; n_err++;
            $display("FAIL max_ramp_timeout: level_l %0d never exceeded 40000", lvl_l);
        end
        cyc(2 * LED_DIV);
        chk("max_leds", 32'(leds), 32'b011111);
        chk("max_chan", 32'(chan), 32'd0);
        mode = 2'd1;
        cyc(2 * LED_DIV);
        chk("right_leds", 32'(leds), 32'd0);
        chk("right_chan", 32'(chan), 32'd1);

        // Alternate mode: chan_o flips every ALT_TICKS*LED_DIV = 16 cycles.
        mode = 2'd3;
        cyc(3 * LED_DIV);
        prev = chan; changes = 0;
        for (int i = 0; i < 64; i++) begin
            cyc(1);
            if (chan != prev) changes++;
            prev = chan;
            if (i % 8 == 0)
                chk("alt_leds_track", 32'(leds), chan ? 32'd0 : 32'b011111);
        end
        chk("alt_toggle_count", 32'(changes), 32'd4);

        // Reset asserted in the UPD_L cycle.
        mode = 2'd0;
        stb = 1'b1; cyc(1); stb = 1'b0;             // now in UPD_L
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_lvl_l", lvl_l, 32'd0);
        chk("midrst_lvl_r", lvl_r, 32'd0);
        chk("midrst_leds", 32'(leds), 32'd0);
        cyc(2);
        chk("midrst_stays_idle", 32'(busy), 32'd0);
        chk("midrst_no_write", lvl_l, 32'd0);
        cyc(2);

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
